assert_req_ack_mon: RTL and testbench
=====================================

Name: assert_req_ack_mon

Overview:
- Temporal protocol monitor for single-outstanding req/ack handshakes (CPU-to-memory, CPU-to-IO).
- Sits directly upstream of the combinational-free assertion checkers. Its registered `viol` output drives the `test` input of an `assert_never` instance.
- Its `viol_code`/`err` outputs feed bench logging.
- Converts multi-cycle protocol rules (latency window, stability, tag match) into a single-cycle violation pulse.

Parameters:
- MIN_LAT, 1, minimum legal req-to-ack latency in cycles; 0 allows same-cycle ack.
- MAX_LAT, 8, maximum legal latency; must satisfy MAX_LAT >= MIN_LAT and MAX_LAT >= 1.
- TAG_W, 4, width of the request/ack tag.
- CNT_W, 8, width of the saturating violation counter.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- req, input, 1, request valid; held high until ack.
- req_tag, input, TAG_W, tag accompanying req; must be stable while req is pending.
- ack, input, 1, response strobe, one cycle.
- ack_tag, input, TAG_W, tag returned with ack.
- clr, input, 1, synchronous clear of `err` and `viol_cnt`.
- viol, output, 1, one-cycle pulse, registered, one cycle after the offending sample.
- viol_code, output, 3, cause of the current `viol`; 0 when `viol`=0.
- err, output, 1, sticky OR of all violations.
- viol_cnt, output, CNT_W, saturating count of violations.
- txn_done, output, 1, one-cycle pulse per legally completed transaction.
- busy, output, 1, high while in WAIT.

Behaviour:
- Reset (async, `rst_n`=0): state=IDLE, lat_cnt=0, held tag=0; `viol`, `viol_code`, `err`, `viol_cnt`, `txn_done` all 0.
- Violation codes: 1 SPURIOUS (ack with no pending req), 2 EARLY (ack before MIN_LAT), 3 TIMEOUT (no ack by MAX_LAT), 4 DROP (req fell before ack), 5 UNSTABLE (`req_tag` changed while pending), 6 TAGMIS (`ack_tag` != held tag), 7 XPROP (optional feature only).
- Latency definition: the cycle req is first sampled high is cycle 0. An ack sampled k cycles later has latency k. lat_cnt holds k.
- States: IDLE, WAIT, DRAIN.
- IDLE:
  - req=1, ack=1: if MIN_LAT=0 and tags match → `txn_done`. MIN_LAT=0 with mismatch → TAGMIS. MIN_LAT>0 → EARLY. Stay in IDLE.
  - req=1, ack=0: capture `req_tag`, lat_cnt=1, → WAIT.
  - req=0, ack=1: SPURIOUS.
- WAIT, checks evaluated in priority order, only the highest reported per cycle:
  - req=0 and ack=0 → DROP, → IDLE.
  - `req_tag` != held tag → UNSTABLE, → DRAIN.
  - ack=1 and lat_cnt < MIN_LAT → EARLY, → IDLE.
  - ack=1 and `ack_tag` mismatch → TAGMIS, → IDLE.
  - ack=1 otherwise → `txn_done`, → IDLE.
  - ack=0 and lat_cnt == MAX_LAT → TIMEOUT, → DRAIN.
  - else lat_cnt++.
- WAIT note: req=0 together with ack=1 in the same cycle is an ack on the falling-req cycle. It is treated as an ack, not a DROP.
- DRAIN: no further violations reported. → IDLE once req=0 is sampled; a late ack is ignored. Prevents cascaded reports from a single fault.
- Outputs:
  - `viol`, `viol_code` and `txn_done` are registered and asserted exactly one cycle after the sampling edge.
  - `busy` = (state==WAIT), registered state decode.
  - `err` sets with `viol` and stays set until `clr` or reset.
  - `viol_cnt` increments with `viol` and saturates at 2^CNT_W-1.
  - `clr` and a new violation in the same cycle: clear wins, then the count becomes 1 and `err`=1. The new event is never lost.
- Reset mid-transaction: immediate return to IDLE. The pending request is forgotten and reported as nothing.
- Back-to-back: ack completing in WAIT with req still high → IDLE. The next cycle, req high is sampled as a new request at cycle 0.

Optional Feature:
- Macro: ASSERT_REQ_ACK_MON_XCHK_EN.
- When defined:
  - Any cycle out of reset where req or ack is not 0/1 (`===` check), or req=1 with any X/Z in `req_tag` → XPROP (code 7).
  - XPROP has top priority and forces state to IDLE.
- When undefined: no X checking logic is compiled, and code 7 is never produced.

Test Plan (MIN_LAT=2, MAX_LAT=5, TAG_W=4):
- Legal transaction: req rises with tag=0xA, ack with `ack_tag`=0xA at latency 3 → `txn_done`=1 one cycle later; `viol`=0, `err`=0.
- Early ack: ack at latency 1 → `viol`=1, `viol_code`=2, `viol_cnt`=1, state IDLE.
- Timeout: req held with no ack → `viol_code`=3 one cycle after the latency-5 sample. A late ack at latency 7 is ignored, and IDLE is reached after req=0.
- Drop, tag mismatch and spurious: req falls at latency 2 with no ack → code 4. Separately, `ack_tag`=0x3 against held 0xA → code 6. Separately, ack with req=0 in IDLE → code 1. After all three, `viol_cnt`=3 and `err`=1.
- Async reset asserted mid-WAIT → all outputs 0 immediately, no `viol` after release. Then `clr` and a TAGMIS in the same cycle → `viol_cnt`=1, `err`=1.
- With ASSERT_REQ_ACK_MON_XCHK_EN defined: req=1'bx for one cycle → `viol_code`=7. Without the macro, the same stimulus gives no code 7.

Source files
------------

// File: rtl/assert_req_ack_mon_if.sv
// Handshake bundle for assert_req_ack_mon: req/ack stimulus side (master) and the
// monitor side (slave) that returns the registered violation/status outputs.
interface assert_req_ack_mon_if #(
    parameter int unsigned TAG_W = 4,
    parameter int unsigned CNT_W = 8
) ();

    logic             req;
    logic [TAG_W-1:0] req_tag;
    logic             ack;
    logic [TAG_W-1:0] ack_tag;
    logic             clr;
    logic             viol;
    logic [2:0]       viol_code;
    logic             err;
    logic [CNT_W-1:0] viol_cnt;
    logic             txn_done;
    logic             busy;

    modport master (
        output req, req_tag, ack, ack_tag, clr,
        input  viol, viol_code, err, viol_cnt, txn_done, busy
    );

    modport slave (
        input  req, req_tag, ack, ack_tag, clr,
        output viol, viol_code, err, viol_cnt, txn_done, busy
    );

endinterface

// File: rtl/assert_req_ack_mon.sv
// Single-outstanding req/ack protocol monitor: folds latency, stability and tag rules into a
// registered one-cycle viol pulse. Define ASSERT_REQ_ACK_MON_XCHK_EN to add X/Z checking.
module assert_req_ack_mon #(
    parameter int unsigned MIN_LAT = 1,
    parameter int unsigned MAX_LAT = 8,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned CNT_W   = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    assert_req_ack_mon_if.slave bus
);

    localparam int unsigned    LatW   = $clog2(MAX_LAT + 1);
    localparam logic [LatW-1:0] MinLat = LatW'(MIN_LAT);
    localparam logic [LatW-1:0] MaxLat = LatW'(MAX_LAT);

    localparam logic [2:0] CodeNone     = 3'd0;
    localparam logic [2:0] CodeSpurious = 3'd1;
    localparam logic [2:0] CodeEarly    = 3'd2;
    localparam logic [2:0] CodeTimeout  = 3'd3;
    localparam logic [2:0] CodeDrop     = 3'd4;
    localparam logic [2:0] CodeUnstable = 3'd5;
    localparam logic [2:0] CodeTagmis   = 3'd6;
`ifdef ASSERT_REQ_ACK_MON_XCHK_EN
    localparam logic [2:0] CodeXprop    = 3'd7;
`endif

    typedef enum logic [1:0] {StIdle, StWait, StDrain} state_e;

    state_e           state_q, state_d;
    logic [LatW-1:0]  lat_q, lat_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [2:0]       code_d, code_q;
    logic             done_d, done_q;
    logic             viol_d, viol_q;
    logic             busy_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        tag_d   = tag_q;
        code_d  = CodeNone;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.req && bus.ack) begin
                    if (MIN_LAT != 0)                   code_d = CodeEarly;
                    else if (bus.ack_tag != bus.req_tag) code_d = CodeTagmis;
                    else                                 done_d = 1'b1;
                end else if (bus.req) begin
                    tag_d   = bus.req_tag;
                    lat_d   = LatW'(1);
                    state_d = StWait;
                end else if (bus.ack) begin
                    code_d = CodeSpurious;
                end
            end
            StWait: begin
                // Ack on the cycle req falls still counts as an ack, so DROP needs ack=0.
                if (!bus.req && !bus.ack) begin
                    code_d  = CodeDrop;
                    state_d = StIdle;
                end else if (bus.req_tag != tag_q) begin
                    code_d  = CodeUnstable;
                    state_d = StDrain;
                end else if (bus.ack) begin
                    state_d = StIdle;
                    if (lat_q < MinLat)            code_d = CodeEarly;
                    else if (bus.ack_tag != tag_q) code_d = CodeTagmis;
                    else                           done_d = 1'b1;
                end else if (lat_q == MaxLat) begin
                    code_d  = CodeTimeout;
                    state_d = StDrain;
                end else begin
                    lat_d = lat_q + LatW'(1);
                end
            end
            StDrain: begin
                // Swallow everything until req drops so one fault yields one report.
                if (!bus.req) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
`ifdef ASSERT_REQ_ACK_MON_XCHK_EN
        if ($isunknown({bus.req, bus.ack}) || (bus.req === 1'b1 && $isunknown(bus.req_tag))) begin
            code_d  = CodeXprop;
            done_d  = 1'b0;
            state_d = StIdle;
        end
`endif
        viol_d = (code_d != CodeNone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            lat_q   <= '0;
            tag_q   <= '0;
            viol_q  <= 1'b0;
            code_q  <= CodeNone;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            tag_q   <= tag_d;
            viol_q  <= viol_d;
            code_q  <= code_d;
            done_q  <= done_d;
            busy_q  <= (state_d == StWait);
            // Clear first, then let a same-cycle violation land so it is never lost.
            if (bus.clr) begin
                err_q <= viol_d;
                cnt_q <= viol_d ? CNT_W'(1) : '0;
            end else if (viol_d) begin
                err_q <= 1'b1;
                if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.viol      = viol_q;
    assign bus.viol_code = code_q;
    assign bus.txn_done  = done_q;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;
    assign bus.viol_cnt  = cnt_q;

endmodule

// File: tb/tb_assert_req_ack_mon.sv
// Directed bench for assert_req_ack_mon (MIN_LAT=2, MAX_LAT=5); expected events are queued
// by the stimulus and consumed by an independent negedge monitor.
module tb_assert_req_ack_mon;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b1;

    typedef struct {
        int         due;
        logic [2:0] code;
        bit         done;
    } exp_t;

    exp_t sb[$];

    assert_req_ack_mon_if #(.TAG_W(4), .CNT_W(8)) bus ();

    assert_req_ack_mon #(
        .MIN_LAT(2),
        .MAX_LAT(5),
        .TAG_W  (4),
        .CNT_W  (8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Apply one input vector for one sample edge; a non-zero code or done queues the event
    // that must appear one cycle after the sample.
    task automatic drive(input logic r, input logic [3:0] rt, input logic a, input logic [3:0] at,
                         input int code, input bit done);
        bus.req     = r;
        bus.req_tag = rt;
        bus.ack     = a;
        bus.ack_tag = at;
        if (code != 0 || done) sb.push_back('{due: cyc + 1, code: 3'(code), done: done});
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 4'h0, 1'b0, 4'h0, 0, 1'b0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && mon_en) begin
            if (bus.viol || bus.txn_done) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event @%0d: got viol=%0b code=%0d done=%0b, required none",
                             cyc, bus.viol, bus.viol_code, bus.txn_done);
                end else begin
                    e = sb.pop_front();
                    if ({bus.viol, bus.viol_code, bus.txn_done} !== {e.code != 3'd0, e.code, e.done}
                        || cyc != e.due) begin
                        errors++;
                        $display("FAIL event @%0d: got viol=%0b code=%0d done=%0b, required code=%0d done=%0b @%0d",
                                 cyc, bus.viol, bus.viol_code, bus.txn_done, e.code, e.done, e.due);
                    end
                end
            end else if (sb.size() != 0 && sb[0].due < cyc) begin
                checks++;
                errors++;
                e = sb.pop_front();
                $display("FAIL missing_event @%0d: got nothing, required code=%0d done=%0b @%0d",
                         cyc, e.code, e.done, e.due);
            end else if (bus.viol_code != 3'd0) begin
                checks++;
                errors++;
                $display("FAIL code_without_viol @%0d: got code=%0d, required 0", cyc, bus.viol_code);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen7;
        bus.req = 1'b0; bus.req_tag = '0; bus.ack = 1'b0; bus.ack_tag = '0; bus.clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {17'd0, bus.viol, bus.viol_code, bus.err, bus.viol_cnt, bus.txn_done,
                              bus.busy}, 32'd0);
        rst_n = 1'b1;
        idle();

        // Legal transaction, latency 3.
        drive(1'b1, 4'hA, 1'b0, 4'h0, 0, 1'b0);
        chk("busy_in_wait", 32'(bus.busy), 32'd1);
        drive(1'b1, 4'hA, 1'b0, 4'h0, 0, 1'b0);
        drive(1'b1, 4'hA, 1'b0, 4'h0, 0, 1'b0);
        drive(1'b1, 4'hA, 1'b1, 4'hA, 0, 1'b1);
        idle();
        chk("legal_err_cnt", {23'd0, bus.err, bus.viol_cnt}, 32'd0);

        // Early ack at latency 1.
        drive(1'b1, 4'hA, 1'b0, 4'h0, 0, 1'b0);
        drive(1'b1, 4'hA, 1'b1, 4'hA, 2, 1'b0);
        chk("early_cnt", 32'(bus.viol_cnt), 32'd1);
        chk("early_err_idle", {30'd0, bus.err, bus.busy}, 32'h2);
        idle();

        // Timeout at latency 5, late ack at 7 ignored, leave DRAIN on req=0.
        drive(1'b1, 4'hA, 1'b0, 4'h0, 0, 1'b0);
        repeat (4) drive(1'b1, 4'hA, 1'b0, 4'h0, 0, 1'b0);
        drive(1'b1, 4'hA, 1'b0, 4'h0, 3, 1'b0);
        chk("drain_not_busy", 32'(bus.busy), 32'd0);
        drive(1'b1, 4'hA, 1'b0, 4'h0, 0, 1'b0);
        drive(1'b1, 4'hA, 1'b1, 4'hA, 0, 1'b0);
        idle();
        chk("timeout_cnt", 32'(bus.viol_cnt), 32'd2);

        // Clear alone, then drop / tag mismatch / spurious.
        bus.clr = 1'b1;
        idle();
        bus.clr = 1'b0;
        chk("clr_only", {23'd0, bus.err, bus.viol_cnt}, 32'd0);
        drive(1'b1, 4'hA, 1'b0, 4'h0, 0, 1'b0);
        drive(1'b1, 4'hA, 1'b0, 4'h0, 0, 1'b0);
        drive(1'b0, 4'hA, 1'b0, 4'h0, 4, 1'b0);
        drive(1'b1, 4'hA, 1'b0, 4'h0, 0, 1'b0);
        drive(1'b1, 4'hA, 1'b0, 4'h0, 0, 1'b0);
        drive(1'b1, 4'hA, 1'b1, 4'h3, 6, 1'b0);
        idle();
        drive(1'b0, 4'h0, 1'b1, 4'h0, 1, 1'b0);
        idle();
        chk("three_viol", {23'd0, bus.err, bus.viol_cnt}, {23'd0, 1'b1, 8'd3});

        // Boundaries: ack at MIN_LAT back-to-back with a new request, ack at MAX_LAT.
        drive(1'b1, 4'hA, 1'b0, 4'h0, 0, 1'b0);
        drive(1'b1, 4'hA, 1'b0, 4'h0, 0, 1'b0);
        drive(1'b1, 4'hA, 1'b1, 4'hA, 0, 1'b1);
        drive(1'b1, 4'h5, 1'b0, 4'h0, 0, 1'b0);
        repeat (4) drive(1'b1, 4'h5, 1'b0, 4'h0, 0, 1'b0);
        drive(1'b1, 4'h5, 1'b1, 4'h5, 0, 1'b1);
        idle();

        // Ack on the falling-req cycle, unstable tag, same-cycle req+ack in IDLE.
        drive(1'b1, 4'h2, 1'b0, 4'h0, 0, 1'b0);
        drive(1'b1, 4'h2, 1'b0, 4'h0, 0, 1'b0);
        drive(1'b0, 4'h2, 1'b1, 4'h2, 0, 1'b1);
        drive(1'b1, 4'hA, 1'b0, 4'h0, 0, 1'b0);
        drive(1'b1, 4'hB, 1'b0, 4'h0, 5, 1'b0);
        drive(1'b1, 4'hB, 1'b1, 4'hB, 0, 1'b0);
        idle();
        drive(1'b1, 4'hA, 1'b1, 4'hA, 2, 1'b0);
        idle();
        chk("cnt_after_misc", 32'(bus.viol_cnt), 32'd5);

        // Async reset mid-WAIT.
        drive(1'b1, 4'hA, 1'b0, 4'h0, 0, 1'b0);
        drive(1'b1, 4'hA, 1'b0, 4'h0, 0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", {17'd0, bus.viol, bus.viol_code, bus.err, bus.viol_cnt, bus.txn_done,
                            bus.busy}, 32'd0);
        bus.req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) idle();
        chk("post_reset_quiet", {23'd0, bus.err, bus.viol_cnt}, 32'd0);

        // clr together with a TAGMIS.
        drive(1'b0, 4'h0, 1'b1, 4'h0, 1, 1'b0);
        drive(1'b1, 4'hA, 1'b0, 4'h0, 0, 1'b0);
        drive(1'b1, 4'hA, 1'b0, 4'h0, 0, 1'b0);
        bus.clr = 1'b1;
        drive(1'b1, 4'hA, 1'b1, 4'h3, 6, 1'b0);
        bus.clr = 1'b0;
        idle();
        chk("clr_with_viol", {23'd0, bus.err, bus.viol_cnt}, {23'd0, 1'b1, 8'd1});

        // Counter saturation.
        for (int i = 0; i < 260; i++) drive(1'b0, 4'h0, 1'b1, 4'h0, 1, 1'b0);
        idle();
        chk("cnt_saturate", 32'(bus.viol_cnt), 32'd255);
        repeat (3) idle();
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        // X on req for one cycle.
        mon_en = 1'b0;
        seen7  = 1'b0;
        drive(1'bx, 4'hA, 1'b0, 4'h0, 0, 1'b0);
        bus.req = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.viol_code == 3'd7) seen7 = 1'b1;
        end
`ifdef ASSERT_REQ_ACK_MON_XCHK_EN
        chk("xprop_code7", 32'(seen7), 32'd1);
`else
        chk("no_code7", 32'(seen7), 32'd0);
`endif
        rst_n = 1'b0;
        #20;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
